key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 25 ++
 rtl/key_sync.sv | 44 ++++
 rtl/key_debounce.sv | 130 +++++++++++++
 tb/tb_key_debounce.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
//------------------------------------------------------------------------------
// Module      : key_debounce_pkg
// Description : Shared state encoding, default filter length and counter sizing
//               for the push-button debouncer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package key_debounce_pkg;

    // 20 ms at 50 MHz
    localparam int unsigned C_DEB_CYCLES_DEFAULT = 1000000;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FILT_DN = 2'd1;
    localparam logic [1:0] DOWN    = 2'd2;
    localparam logic [1:0] FILT_UP = 2'd3;

    function automatic int unsigned deb_cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_sync.sv
//------------------------------------------------------------------------------
// Module      : key_sync
// Description : Three-flop synchroniser for the raw key level with falling and
//               rising edge detection on the settled end of the chain.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_sync
    import key_debounce_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic s2,
    output logic fall_det,
    output logic rise_det
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Chain resets to the released level so a key held through reset
    // still produces a fresh falling edge afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= key_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign s2       = r_s2;
    assign fall_det = r_s3 & ~r_s2;
    assign rise_det = ~r_s3 & r_s2;

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
//------------------------------------------------------------------------------
// Module      : key_debounce
// Description : Active-low push-button debouncer: four-state filter FSM with a
//               stable-time counter, registered press/release pulses and level.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = C_DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_rel_flag,
    output logic key_state
);

    localparam int unsigned     CNT_W      = deb_cnt_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    // Edges carry all the information the FSM needs; the level tap is unused.
    logic w_s2_unused;
    logic w_fall_det;
    logic w_rise_det;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_key_flag;
    logic             r_key_rel_flag;
    logic             r_key_state;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_key_flag_nxt;
    logic             w_key_rel_flag_nxt;
    logic             w_key_state_nxt;
    logic             w_cnt_last;

    key_sync u_key_sync (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .s2       (w_s2_unused),
        .fall_det (w_fall_det),
        .rise_det (w_rise_det)
    );

    assign w_cnt_last = (r_cnt == C_CNT_LAST);

    // A bounce edge is tested before the terminal count so it always wins.
    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_key_flag_nxt     = 1'b0;
        w_key_rel_flag_nxt = 1'b0;
        w_key_state_nxt    = r_key_state;
        case (r_state)
            IDLE: begin
                if (w_fall_det) begin
                    w_state_nxt = FILT_DN;
                    w_cnt_nxt   = '0;
                end
            end
            FILT_DN: begin
                if (w_rise_det) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_last) begin
                    w_state_nxt     = DOWN;
                    w_cnt_nxt       = '0;
                    w_key_flag_nxt  = 1'b1;
                    w_key_state_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            DOWN: begin
                if (w_rise_det) begin
                    w_state_nxt = FILT_UP;
                    w_cnt_nxt   = '0;
                end
            end
            FILT_UP: begin
                if (w_fall_det) begin
                    w_state_nxt = DOWN;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_last) begin
                    w_state_nxt        = IDLE;
                    w_cnt_nxt          = '0;
                    w_key_rel_flag_nxt = 1'b1;
                    w_key_state_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_key_flag     <= 1'b0;
            r_key_rel_flag <= 1'b0;
            r_key_state    <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_key_flag     <= w_key_flag_nxt;
            r_key_rel_flag <= w_key_rel_flag_nxt;
            r_key_state    <= w_key_state_nxt;
        end
    end

    assign key_flag     = r_key_flag;
    assign key_rel_flag = r_key_rel_flag;
    assign key_state    = r_key_state;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
//------------------------------------------------------------------------------
// Module      : tb_key_debounce
// Description : Directed self-checking bench for key_debounce with an 8-cycle
//               filter; pulses are expected 11 samples after the driving step.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_debounce;

    localparam int unsigned DEB = 8;

    logic clk = 1'b0;
    logic rst;
    logic key_in;
    logic key_flag;
    logic key_rel_flag;
    logic key_state;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int n_press   = 0;
    int n_rel     = 0;
    int last_kind = 0;
    int alt_err   = 0;
    int overlap   = 0;
    int p0;
    int r0;

    key_debounce #(
        .DEB_CYCLES (DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .key_flag     (key_flag),
        .key_rel_flag (key_rel_flag),
        .key_state    (key_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: sample just after the rising edge and log any pulses.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (key_flag && key_rel_flag) overlap++;
        if (key_flag) begin
            n_press++;
            if (last_kind == 1) alt_err++;
            last_kind = 1;
        end
        if (key_rel_flag) begin
            n_rel++;
            if (last_kind == 2) alt_err++;
            last_kind = 2;
        end
        if (rst) last_kind = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst    = 1'b1;
        key_in = 1'b0;

        // Reset with the key held low
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("reset_outputs", int'({key_state, key_flag, key_rel_flag}), 3'b100);
        end

        // Key held through reset release: fresh press after the full filter
        rst = 1'b0;
        steps(10);
        check_eq("por_press_early", int'({key_flag, key_state}), 2'b01);
        step();
        check_eq("por_press_pulse", int'({key_flag, key_state}), 2'b10);
        steps(20);
        check_eq("por_press_count", n_press, 1);

        // Clean release
        key_in = 1'b1;
        steps(10);
        check_eq("rel_early", int'({key_rel_flag, key_state}), 2'b00);
        step();
        check_eq("rel_pulse", int'({key_rel_flag, key_state}), 2'b11);
        steps(10);
        check_eq("rel_count", n_rel, 1);

        // Clean press, then hold with no auto-repeat
        key_in = 1'b0;
        steps(10);
        check_eq("press_early", int'({key_flag, key_state}), 2'b01);
        step();
        check_eq("press_pulse", int'({key_flag, key_state}), 2'b10);
        step();
        check_eq("press_one_cycle", int'(key_flag), 0);
        steps(40);
        check_eq("press_hold_count", n_press, 2);
        check_eq("press_hold_state", int'(key_state), 0);

        key_in = 1'b1;
        steps(20);
        check_eq("rel2_count", n_rel, 2);

        // Press with bounce: low 5, high 2, low held
        p0 = n_press;
        key_in = 1'b0;
        steps(5);
        key_in = 1'b1;
        steps(2);
        key_in = 1'b0;
        steps(10);
        check_eq("bounce_no_early", n_press, p0);
        step();
        check_eq("bounce_pulse", int'({key_flag, key_state}), 2'b10);
        steps(10);
        check_eq("bounce_count", n_press, p0 + 1);

        // Release with bounce: high 4, low 1, high held
        r0 = n_rel;
        key_in = 1'b1;
        steps(4);
        key_in = 1'b0;
        steps(1);
        key_in = 1'b1;
        steps(10);
        check_eq("rel_bounce_no_early", n_rel, r0);
        step();
        check_eq("rel_bounce_pulse", int'({key_rel_flag, key_state}), 2'b11);
        steps(10);
        check_eq("rel_bounce_count", n_rel, r0 + 1);

        // Reset in the middle of the press filter
        p0 = n_press;
        key_in = 1'b0;
        steps(6);
        rst = 1'b1;
        step();
        check_eq("midfilt_reset", int'({key_state, key_flag, key_rel_flag}), 3'b100);
        rst = 1'b0;
        steps(10);
        check_eq("midfilt_no_early", n_press, p0);
        step();
        check_eq("midfilt_pulse", int'({key_flag, key_state}), 2'b10);
        steps(10);
        check_eq("midfilt_count", n_press, p0 + 1);

        // Reset while DOWN with the key released: no release pulse
        r0 = n_rel;
        key_in = 1'b1;
        rst = 1'b1;
        step();
        check_eq("down_reset", int'({key_state, key_rel_flag}), 2'b10);
        rst = 1'b0;
        steps(20);
        check_eq("down_reset_no_rel", n_rel, r0);
        check_eq("down_reset_state", int'(key_state), 1);

        // Five clean press/release cycles
        p0 = n_press;
        r0 = n_rel;
        for (int k = 0; k < 5; k++) begin
            key_in = 1'b0;
            steps(20);
            key_in = 1'b1;
            steps(20);
        end
        check_eq("rep_press_count", n_press - p0, 5);
        check_eq("rep_rel_count", n_rel - r0, 5);
        check_eq("rep_final_state", int'(key_state), 1);
        check_eq("alternation_errors", alt_err, 0);
        check_eq("flag_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
